// File: rtl/aliens_map_pkg.sv
// Memory-map types and constants shared by the Aliens bus controller and decoder.
package aliens_map_pkg;

  typedef enum logic [2:0] {
    RGN_PROG,
    RGN_BANK,
    RGN_WORK,
    RGN_PAL,
    RGN_IO
  } region_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic       init;
    logic       woco;
    logic [4:0] rom_bank;
  } bank_reg_t;

  localparam int unsigned WS_W = 4;

  localparam logic [2:0] A_LOW_WIN  = 3'b000;  // A15:13 work/palette window
  localparam logic [2:0] A_BANK_WIN = 3'b001;  // A15:13 banked ROM window
  localparam logic [1:0] A_IO_WIN   = 2'b01;   // A15:14 IO region
  localparam logic [5:0] A_PAL_WIN  = 6'b000000;  // A15:10 palette overlay

endpackage

// File: rtl/aliens_region_decode.sv
// Combinational Aliens address decode: address plus bank/control bits to one region.
module aliens_region_decode
  import aliens_map_pkg::*;
(
  input  logic [15:0] addr,
  input  logic        bk4,
  input  logic        woco,
  output region_t     region
);

  always_comb begin
    region = RGN_WORK;
    if (addr[15]) begin
      region = RGN_PROG;
    end else if (addr[15:14] == A_IO_WIN) begin
      region = RGN_IO;
    end else if (addr[15:13] == A_BANK_WIN) begin
      region = bk4 ? RGN_PROG : RGN_BANK;
    end else if (addr[15:13] == A_LOW_WIN && addr[12:10] == A_PAL_WIN[2:0] && woco) begin
      region = RGN_PAL;
    end
  end

endmodule

// File: rtl/aliens_bus_ctrl.sv
// Clocked, wait-state-aware bus-cycle controller for the Aliens CPU address space.
// Optional bank-register readback is enabled by defining ALIENS_BANK_READBACK_EN.
module aliens_bus_ctrl
  import aliens_map_pkg::*;
#(
  parameter logic [3:0]  PROG_WS       = 4'd0,
  parameter logic [3:0]  BANK_WS       = 4'd1,
  parameter logic [3:0]  WORK_WS       = 4'd0,
  parameter logic [3:0]  PAL_WS        = 4'd1,
  parameter logic [3:0]  IO_WS         = 4'd2,
  parameter logic [15:0] BANK_REG_ADDR = 16'h5F88
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        as_n,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        dout_en,
  output logic        prog_cs_n,
  output logic        bank_cs_n,
  output logic        work_cs_n,
  output logic        pal_cs_n,
  output logic        io_cs_n,
  output logic        rdy,
  output logic [4:0]  rom_bank,
  output logic        bk4,
  output logic        woco,
  output logic        init
);

  state_t          state, state_nxt;
  region_t         dec_region, region_q;
  logic            wr_q, hit_q;
  logic [WS_W-1:0] cnt_q, cnt_nxt, ws_sel;
  bank_reg_t       bank_q;

  logic [4:0]      sel_nxt;
  logic            rdy_nxt, load_bank, dout_en_nxt;
  logic [7:0]      dout_nxt;
  logic            active, done;

  logic            unused_din7;
  assign unused_din7 = din[7];

  aliens_region_decode u_decode (
    .addr   (addr),
    .bk4    (bank_q.rom_bank[4]),
    .woco   (bank_q.woco),
    .region (dec_region)
  );

  always_comb begin
    ws_sel = '0;
    case (dec_region)
      RGN_PROG: ws_sel = rw ? PROG_WS : '0;  // writes to ROM complete immediately
      RGN_BANK: ws_sel = BANK_WS;
      RGN_WORK: ws_sel = WORK_WS;
      RGN_PAL:  ws_sel = PAL_WS;
      RGN_IO:   ws_sel = IO_WS;
      default:  ws_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt_q    <= '0;
      region_q <= RGN_WORK;
      wr_q     <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt_q <= cnt_nxt;
      if (state == ST_IDLE && !as_n) begin
        region_q <= dec_region;
        wr_q     <= !rw;
        hit_q    <= (addr == BANK_REG_ADDR) && (dec_region == RGN_IO);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_q;
    case (state)
      ST_IDLE: begin
        if (!as_n) begin
          state_nxt = ST_ACCESS;
          cnt_nxt   = ws_sel;
        end
      end
      ST_ACCESS: begin
        if (as_n)             state_nxt = ST_IDLE;
        else if (cnt_q == '0) state_nxt = ST_HOLD;
        else                  cnt_nxt   = cnt_q - 1'b1;
      end
      ST_HOLD: begin
        if (as_n) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered one edge behind the state, so the
  // release after as_n rises lands one cycle after leaving HOLD.
  always_comb begin
    sel_nxt     = '0;
    dout_nxt    = '0;
    dout_en_nxt = 1'b0;
    active      = (state == ST_ACCESS && !as_n) || (state == ST_HOLD);
    done        = (state == ST_ACCESS && !as_n && cnt_q == '0) || (state == ST_HOLD);
    rdy_nxt     = done;
    load_bank   = (state == ST_ACCESS) && !as_n && (cnt_q == '0) && wr_q && hit_q;
    if (active) begin
      case (region_q)
        RGN_PROG: sel_nxt[4] = !wr_q;
        RGN_BANK: sel_nxt[3] = 1'b1;
        RGN_WORK: sel_nxt[2] = 1'b1;
        RGN_PAL:  sel_nxt[1] = 1'b1;
        RGN_IO:   sel_nxt[0] = 1'b1;
        default:  sel_nxt    = '0;
      endcase
    end
`ifdef ALIENS_BANK_READBACK_EN
    if (done && !wr_q && hit_q) begin
      dout_nxt    = {1'b0, bank_q};
      dout_en_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {prog_cs_n, bank_cs_n, work_cs_n, pal_cs_n, io_cs_n} <= '1;
      rdy     <= 1'b0;
      dout    <= '0;
      dout_en <= 1'b0;
      bank_q  <= '0;
    end else begin
      {prog_cs_n, bank_cs_n, work_cs_n, pal_cs_n, io_cs_n} <= ~sel_nxt;
      rdy     <= rdy_nxt;
      dout    <= dout_nxt;
      dout_en <= dout_en_nxt;
      if (load_bank) begin
        bank_q <= '{init: din[6], woco: din[5], rom_bank: din[4:0]};
      end
    end
  end

  assign rom_bank = bank_q.rom_bank;
  assign bk4      = bank_q.rom_bank[4];
  assign woco     = bank_q.woco;
  assign init     = bank_q.init;

endmodule

// File: tb/tb_aliens_bus_ctrl.sv
// Self-checking bench for aliens_bus_ctrl: directed map cases plus random transactions
// checked cycle by cycle against a transaction-level reference model.
module tb_aliens_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        as_n = 1'b1;
  logic        rw = 1'b1;
  logic [15:0] addr = '0;
  logic [7:0]  din = '0;
  logic [7:0]  dout;
  logic        dout_en;
  logic        prog_cs_n, bank_cs_n, work_cs_n, pal_cs_n, io_cs_n;
  logic        rdy;
  logic [4:0]  rom_bank;
  logic        bk4, woco, init;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model state: the bank/control register
  logic [4:0]  m_bank = '0;
  logic        m_woco = 1'b0;
  logic        m_init = 1'b0;

  // per-region wait states, index PROG,BANK,WORK,PAL,IO
  int ws_tab[5] = '{0, 1, 0, 1, 2};

`ifdef ALIENS_BANK_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  aliens_bus_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .as_n      (as_n),
    .rw        (rw),
    .addr      (addr),
    .din       (din),
    .dout      (dout),
    .dout_en   (dout_en),
    .prog_cs_n (prog_cs_n),
    .bank_cs_n (bank_cs_n),
    .work_cs_n (work_cs_n),
    .pal_cs_n  (pal_cs_n),
    .io_cs_n   (io_cs_n),
    .rdy       (rdy),
    .rom_bank  (rom_bank),
    .bk4       (bk4),
    .woco      (woco),
    .init      (init)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // 0 PROG, 1 BANK, 2 WORK, 3 PAL, 4 IO
  function automatic int region_of(input logic [15:0] a);
    int v;
    v = int'(a);
    if (v >= 32768) return 0;
    if (v >= 16384) return 4;
    if (v >= 8192)  return m_bank[4] ? 0 : 1;
    if (v < 1024 && m_woco) return 3;
    return 2;
  endfunction

  task automatic check_outputs(input string tag, input bit sel_on, input bit rdy_on,
                               input int r, input bit absorbed, input bit dout_on);
    logic [4:0] exp_cs;
    exp_cs = 5'h1f;
    if (sel_on && !absorbed) exp_cs[4-r] = 1'b0;
    check({tag, ".cs"}, 32'({prog_cs_n, bank_cs_n, work_cs_n, pal_cs_n, io_cs_n}), 32'(exp_cs));
    check({tag, ".rdy"}, 32'(rdy), 32'(rdy_on));
    check({tag, ".bankreg"}, 32'({init, woco, rom_bank}), 32'({m_init, m_woco, m_bank}));
    check({tag, ".bk4"}, 32'(bk4), 32'(m_bank[4]));
    check({tag, ".dout_en"}, 32'(dout_en), 32'(dout_on));
    check({tag, ".dout"}, 32'(dout), dout_on ? 32'({1'b0, m_init, m_woco, m_bank}) : 32'h0);
  endtask

  // Holds as_n low across t sampled edges; completes if t covers the wait states, else aborts.
  task automatic access(input string tag, input logic [15:0] a, input logic r,
                        input logic [7:0] d, input int t);
    int  reg_r, ws, last;
    bit  absorbed, abort_tx, hit, sel_on, rdy_on;
    reg_r    = region_of(a);
    absorbed = (reg_r == 0) && !r;
    ws       = absorbed ? 0 : ws_tab[reg_r];
    abort_tx = t < 2 + ws;
    hit      = (a == 16'h5F88);
    last     = abort_tx ? t + 1 : t + 2;
    addr = a; rw = r; din = d; as_n = 1'b0;
    for (int k = 1; k <= last; k++) begin
      @(posedge clk); #1;
      if (!abort_tx && !r && hit && k == 2 + ws) begin
        m_bank = d[4:0]; m_woco = d[5]; m_init = d[6];
      end
      sel_on = abort_tx ? (k >= 2 && k <= t) : (k >= 2 && k <= t + 1);
      rdy_on = !abort_tx && k >= 2 + ws && k <= t + 1;
      check_outputs(tag, sel_on, rdy_on, reg_r, absorbed, READBACK && rdy_on && r && hit);
      if (k == t) as_n = 1'b1;
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_outputs("reset", 1'b0, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    access("io_ws",      16'h4000, 1'b1, 8'h00, 5);
    access("bank_wr",    16'h5F88, 1'b0, 8'h35, 4);
    check("bank_val", 32'({woco, bk4, rom_bank}), 32'({1'b1, 1'b1, 5'h15}));
    access("prog_bk4",   16'h2000, 1'b1, 8'h00, 3);
    access("pal_woco",   16'h0100, 1'b1, 8'h00, 3);
    access("readback",   16'h5F88, 1'b1, 8'h00, 5);
    access("bank_clr",   16'h5F88, 1'b0, 8'h00, 4);
    access("abort",      16'h2000, 1'b1, 8'h00, 2);
    check("abort_reg", 32'(rom_bank), 32'h0);
    access("absorbed",   16'h8000, 1'b0, 8'hAA, 2);
    access("work",       16'h0100, 1'b1, 8'h00, 3);
    access("io_abort",   16'h5F88, 1'b0, 8'h7F, 3);

    for (int i = 0; i < 80; i++) begin
      logic [15:0] a;
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'h5F88;
      access("rand", a, 1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(1, 6)));
    end

    access("pre_rst_wr", 16'h5F88, 1'b0, 8'h2A, 4);
    addr = 16'h4000; rw = 1'b1; as_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("mid_io_cs", 32'(io_cs_n), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    m_bank = '0; m_woco = 1'b0; m_init = 1'b0;
    check_outputs("async_rst", 1'b0, 1'b0, 4, 1'b0, 1'b0);
    as_n = 1'b1;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_outputs("post_rst", 1'b0, 1'b0, 4, 1'b0, 1'b0);
    access("post_rst_io", 16'h4000, 1'b1, 8'h00, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aliens_bus_ctrl.md
# aliens_bus_ctrl

Registered bus-cycle controller for the Aliens CPU address space. It owns the bank/control register that drives the memory-map decode (`rom_bank`, `bk4`, `woco`, `init`). It decodes each CPU access into one active-low chip select and inserts per-region wait states before asserting `rdy`. It sits between the CPU strobe/address bus and the PROG/BANK/WORK/palette/IO devices, and replaces the purely combinational select path with a clocked, wait-state-aware sequencer.

## Interface
- `PROG_WS`, default 0: wait states for the program ROM region (4-bit).
- `BANK_WS`, default 1: wait states for the banked ROM window.
- `WORK_WS`, default 0: wait states for work RAM.
- `PAL_WS`, default 1: wait states for the palette window.
- `IO_WS`, default 2: wait states for the IO region.
- `BANK_REG_ADDR`, default 16'h5F88: address of the bank/control register inside the IO region.
- `clk  in  1`: system clock. The block has one clock.
- `rst_n  in  1`: reset. Asynchronous, active-low.
- `as_n  in  1`: CPU address strobe, active-low, synchronous to `clk`.
- `rw  in  1`: 1 = read, 0 = write.
- `addr  in  16`: CPU address, stable while `as_n` is low.
- `din  in  8`: CPU write data.
- `dout  out  8`: register readback data (see Configuration).
- `dout_en  out  1`: `dout` is valid this cycle.
- `prog_cs_n`, `bank_cs_n`, `work_cs_n`, `pal_cs_n`, `io_cs_n  out  1 each`: registered chip selects.
- `rdy  out  1`: access complete; the CPU may end the cycle.
- `rom_bank  out  5`: bank register bits [4:0].
- `bk4  out  1`: equals `rom_bank[4]`.
- `woco  out  1`: work/colour select, bank register bit 5.
- `init  out  1`: bank register bit 6.

## Operation
- **Regions.** Decoding uses the register values held at the moment `as_n` is sampled:
  - PROG: `A15=1`, or `A15:13=001` with `bk4=1`.
  - BANK: `A15:13=001` with `bk4=0`.
  - PAL: `A15:10=000000` with `woco=1`.
  - WORK: the rest of `A15:13=000`.
  - IO: `A15:14=01`.
  - The regions are exhaustive and mutually exclusive.
- **FSM states.** IDLE, ACCESS, HOLD.
- **IDLE.** On `as_n` sampled low, latch the region and `ws`, then go to ACCESS.
- **ACCESS.** The region's `cs_n` is low and the counter starts at `ws`. The counter decrements each cycle. When it reaches 0, `rdy` goes to 1 and the FSM moves to HOLD.
- **HOLD.** `cs_n` and `rdy` are held. On `as_n` sampled high, return to IDLE.
- **Write to PROG.** No chip select is asserted. `rdy` follows with 0 wait states; the write is absorbed.
- **Bank register write.** A write with `addr == BANK_REG_ADDR` loads `rom_bank=din[4:0]`, `woco=din[5]`, `init=din[6]`. The load happens on the cycle `rdy` first rises. `io_cs_n` is still asserted for that cycle.
- **Abort.** If `as_n` goes high in ACCESS before `rdy`, go to IDLE next cycle. `cs_n` and `rdy` are released and no register write occurs.
- **Register values are never modified mid-access.** New `bk4`/`woco` values affect only the next access's decode.

## Timing
- **Reset.** All `cs_n`=1, `rdy`=0, `dout`=0, `dout_en`=0, `rom_bank`=0, `bk4`=0, `woco`=0, `init`=0, FSM in IDLE. Reset asserted mid-access releases the selects immediately (asynchronously).
- **Latency.** `as_n` is sampled low at edge N. `cs_n` goes low after edge N+1. `rdy` goes high after edge N+1+ws.
- **Release.** `as_n` is sampled high at edge M. `cs_n` and `rdy` go inactive after edge M+1.
- **Back-to-back.** `as_n` low again at edge M+1 starts a new access from IDLE, with at least one idle cycle between accesses.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`ALIENS_BANK_READBACK_EN` defined.** A read of `BANK_REG_ADDR` drives `dout={1'b0,init,woco,rom_bank}` with `dout_en=1` for every cycle `rdy` is high.
- **Undefined.** `dout`=0 and `dout_en`=0 always. That address behaves as a plain IO read.

## Structure
- **Package `aliens_map_pkg`:** region enum (PROG, BANK, WORK, PAL, IO), the address-field constants, and the FSM state typedef.
- **Sub-module `aliens_region_decode`:** combinational, takes `addr`, `bk4` and `woco`, returns the region. It is instantiated once and is reusable by simulation models.

## Test plan
- **Reset.** Assert `rst_n`=0 mid-IO access → all `cs_n`=1, `rdy`=0, `rom_bank`=0 immediately; IDLE after release.
- **IO wait states.** Read 16'h4000 with `IO_WS`=2 → `io_cs_n` low at N+1, `rdy` at N+3, both held until `as_n` rises, released one cycle later.
- **Bank write.** Write 8'h35 to 16'h5F88 → `rom_bank`=5'h15, `bk4`=1, `woco`=1. Next read of 16'h2000 asserts `prog_cs_n`; next read of 16'h0100 asserts `pal_cs_n`.
- **Abort.** Access 16'h2000 with `bk4`=0 and `BANK_WS`=1; raise `as_n` after `cs` but before `rdy` → no `rdy`, `bank_cs_n` released next cycle, register unchanged.
- **Absorbed write.** Write to 16'h8000 → no `cs_n` asserted, `rdy` at N+1.
- **Readback (macro on).** Read 16'h5F88 after writing 8'h35 → `dout`=8'h35 with `dout_en`=1. Macro off → `dout`=0.
